alu_sequencer: RTL

- Command-level controller in front of the shared combinational 32-bit ALU.
- Accepts one operation at a time over a valid/ready handshake and drives the ALU's a, b and select inputs.
- Single-step ALU ops execute in one cycle. Variable-amount shifts (SLLV/SRLV) are sequenced by iterating the ALU's shift-by-1 ops.
- Captures the result and presents it with a locally computed zero flag on a valid/ready response channel.

---
 rtl/alu_sequencer.sv | 134 +++++++++++++
 1 files changed

// File: rtl/alu_sequencer.sv
// Command sequencer in front of a shared combinational ALU: one-cycle ops go
// straight through, variable shifts are built from repeated shift-by-1 passes.
module alu_sequencer #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_select,
    input  logic [WIDTH-1:0] alu_out,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, EXEC, SHIFT, DONE} state_t;

    localparam logic [3:0] OP_SLLV   = 4'hE;
    localparam logic [3:0] SEL_SHL1  = 4'h8;
    localparam logic [3:0] SEL_SHR1  = 4'h9;
    localparam logic [3:0] SEL_PASSA = 4'hD;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   op_a_q, op_a_d;
    logic [WIDTH-1:0]   op_b_q, op_b_d;
    logic [3:0]         op_q, op_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   rsp_result_q, rsp_result_d;
    logic               rsp_zero_q, rsp_zero_d;

    logic               cmd_is_shift;
    logic               op_is_shift;
    logic [SHAMT_W-1:0] cmd_shamt;

    // Op codes 1110/1111 are the only variable-shift encodings.
    assign cmd_is_shift = (cmd_op[3:1] == 3'b111);
    assign op_is_shift  = (op_q[3:1] == 3'b111);
    assign cmd_shamt    = cmd_b[SHAMT_W-1:0];

    always_comb begin
        state_d      = state_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        op_d         = op_q;
        cnt_d        = cnt_q;
        acc_d        = acc_q;
        rsp_result_d = rsp_result_q;
        rsp_zero_d   = rsp_zero_q;
        alu_a        = '0;
        alu_b        = '0;
        alu_select   = SEL_PASSA;

        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    op_a_d = cmd_a;
                    op_b_d = cmd_b;
                    op_d   = cmd_op;
                    cnt_d  = cmd_is_shift ? cmd_shamt : '0;
                    if (cmd_is_shift && (cmd_shamt != '0)) begin
                        acc_d   = cmd_a;
                        state_d = SHIFT;
                    end else begin
                        state_d = EXEC;
                    end
                end
            end
            EXEC: begin
                alu_a        = op_a_q;
                alu_b        = op_b_q;
                // A zero-length shift degenerates to passing A through.
                alu_select   = op_is_shift ? SEL_PASSA : op_q;
                rsp_result_d = alu_out;
                rsp_zero_d   = (alu_out == '0);
                state_d      = DONE;
            end
            SHIFT: begin
                alu_a      = acc_q;
                alu_b      = '0;
                alu_select = (op_q == OP_SLLV) ? SEL_SHL1 : SEL_SHR1;
                acc_d      = alu_out;
                cnt_d      = cnt_q - SHAMT_W'(1);
                if (cnt_q == SHAMT_W'(1)) begin
                    rsp_result_d = alu_out;
                    rsp_zero_d   = (alu_out == '0);
                    state_d      = DONE;
                end
            end
            DONE: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            op_a_q       <= '0;
            op_b_q       <= '0;
            op_q         <= '0;
            cnt_q        <= '0;
            acc_q        <= '0;
            rsp_result_q <= '0;
            rsp_zero_q   <= 1'b1;
        end else begin
            state_q      <= state_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            op_q         <= op_d;
            cnt_q        <= cnt_d;
            acc_q        <= acc_d;
            rsp_result_q <= rsp_result_d;
            rsp_zero_q   <= rsp_zero_d;
        end
    end

    assign cmd_ready  = (state_q == IDLE);
    assign rsp_valid  = (state_q == DONE);
    assign busy       = (state_q != IDLE);
    assign rsp_result = rsp_result_q;
    assign rsp_zero   = rsp_zero_q;

endmodule
